// File: rtl/if_branch_predictor.sv
// Fetch-stage PC generator with a BTB (direct-mapped) and a 2-bit-counter PHT.
// Optional macro GSHARE_EN: adds a global history register XORed into the PHT index.
module if_branch_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          PHT_IDX_W   = 8,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic [31:0]          imem_rdata,
  input  logic                 ex_br_valid,
  input  logic                 ex_jmp_valid,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic [PHT_IDX_W-1:0] ex_pht_idx,
  output logic [31:0]          imem_addr,
  output logic [31:0]          F_PC,
  output logic [31:0]          F_instruction,
  output logic                 F_pred_taken,
  output logic [PHT_IDX_W-1:0] F_pht_idx,
  output logic                 F_btb_hit,
  output logic [31:0]          F_btb_target
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int SET_W       = $clog2(BTB_ENTRIES);
  localparam int TAG_W       = 30 - SET_W;

  // Architectural state
  logic [31:0]      pc_q, pc_d;
  logic [1:0]       pht_q        [PHT_ENTRIES];
  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [31:0]      btb_target_q [BTB_ENTRIES];

  // Fetch-side lookup
  logic [SET_W-1:0]     fetch_set;
  logic [TAG_W-1:0]     fetch_tag;
  logic [PHT_IDX_W-1:0] pc_idx;
  logic [PHT_IDX_W-1:0] fetch_idx;
  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic                 pred_taken;

  // Training side
  logic                 pht_we;
  logic [1:0]           ctr_old;
  logic [1:0]           ctr_new;
  logic                 btb_we;
  logic [SET_W-1:0]     ex_set;
  logic [TAG_W-1:0]     ex_tag;
  logic [31:0]          ex_target_aligned;
  logic                 ex_pc_unused;

  assign fetch_set = pc_q[SET_W+1:2];
  assign fetch_tag = pc_q[31:SET_W+2];
  assign pc_idx    = pc_q[PHT_IDX_W+1:2];

`ifdef GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;

  assign fetch_idx = pc_idx ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (ex_br_valid) ghr_d = {ghr_q[PHT_IDX_W-2:0], ex_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end
`else
  assign fetch_idx = pc_idx;
`endif

  // Lookup reads the pre-update arrays; training lands on the next edge with no bypass.
  assign btb_hit    = btb_valid_q[fetch_set] && (btb_tag_q[fetch_set] == fetch_tag);
  assign btb_target = btb_hit ? btb_target_q[fetch_set] : 32'h0000_0000;
  assign pred_taken = btb_hit && pht_q[fetch_idx][1];

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = btb_target;
    end
  end

  // Both valids high is illegal; it falls out as a branch update plus a BTB write.
  always_comb begin
    pht_we  = ex_br_valid;
    ctr_old = pht_q[ex_pht_idx];
    ctr_new = ctr_old;
    if (ex_taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'd1;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'd1;
    end
  end

  assign btb_we            = ex_jmp_valid || (ex_br_valid && ex_taken);
  assign ex_set            = ex_pc[SET_W+1:2];
  assign ex_tag            = ex_pc[31:SET_W+2];
  assign ex_target_aligned = ex_target & 32'hFFFF_FFFC;
  assign ex_pc_unused      = ^ex_pc[1:0];

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (pht_we) begin
      pht_q[ex_pht_idx] <= ctr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid_q[ex_set] <= 1'b1;
    end
  end

  // NOTE: only the valid bits need reset; tags and targets are never observed while invalid, so they stay plain RAM.
  always_ff @(posedge clk) begin
    if (rst && btb_we) begin
      btb_tag_q[ex_set]    <= ex_tag;
      btb_target_q[ex_set] <= ex_target_aligned;
    end
  end

  assign imem_addr     = pc_q;
  assign F_PC          = pc_q;
  assign F_instruction = imem_rdata;
  assign F_pred_taken  = pred_taken;
  assign F_pht_idx     = fetch_idx;
  assign F_btb_hit     = btb_hit;
  assign F_btb_target  = btb_target;

endmodule
